// File: rtl/hit_zone_detector.sv
// hit_zone_detector: counts target-colour pixels per frame in NUM_ZONES hit
// zones, picks the strongest qualifying zone at frame end, reports one
// collision with a frame-to-frame speed estimate, then holds off new
// collisions for a programmable number of frames.
//
// Handshake/timing contract: there is no back-pressure anywhere. A pixel is
// consumed on every clock edge where DE is high. frame_done and
// collision_detected are single-cycle strobes with no ready; hit_zone,
// hit_count and estimated_speed are valid from the collision strobe onward
// and hold until the next one. busy is high exactly while the FSM is in EVAL.
module hit_zone_detector #(
  parameter int NUM_ZONES       = 4,
  parameter int CNT_W           = 12,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                 clk_25MHz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 DE,
  input  logic [9:0]           x_pixel,
  input  logic [9:0]           y_pixel,
  input  logic [NUM_ZONES-1:0] is_hit_area,
  input  logic                 is_target_color,
  input  logic [CNT_W-1:0]     thresh,
  output logic                 collision_detected,
  output logic [ZW-1:0]        hit_zone,
  output logic [CNT_W-1:0]     hit_count,
  output logic [9:0]           estimated_speed,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCUM, EVAL, RESULT} state_t;

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] live      [NUM_ZONES];
  logic [CNT_W-1:0] live_next [NUM_ZONES];
  logic [CNT_W-1:0] shadow    [NUM_ZONES];
  logic [CNT_W-1:0] prev      [NUM_ZONES];
  logic [CNT_W-1:0] thresh_q;
  logic [CNT_W-1:0] best_cnt;
  logic [ZW-1:0]    scan_idx;
  logic [ZW-1:0]    best_idx;
  logic             found;
  logic [CD_W-1:0]  cooldown;

  logic             frame_start;
  logic             frame_end;
  logic             snapshot;
  logic             count_en;
  logic [CNT_W-1:0] cur_cnt;
  logic             cur_qual;
  logic [31:0]      diff;
  logic [9:0]       speed;

  // Frame markers; the end marker only counts once a real frame start was seen.
  assign frame_start = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
  assign frame_end   = DE && armed && (x_pixel == 10'(H_ACTIVE - 1))
                       && (y_pixel == 10'(V_ACTIVE - 1));
  // A frame end that lands while a previous snapshot is still being scanned is dropped.
  assign snapshot    = frame_end && (state == ACCUM);
  // The (0,0) pixel arms the detector and is itself counted.
  assign count_en    = DE && is_target_color && (armed || frame_start);

  // Next live count per zone: clear on frame start, then saturating increment.
  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      live_next[i] = frame_start ? '0 : live[i];
      if (count_en && is_hit_area[i] && (live_next[i] != CNT_MAX)) begin
        live_next[i] = live_next[i] + CNT_W'(1);
      end
    end
  end

  // Live counters keep running during EVAL; a snapshot copies them (including the last pixel) and clears.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (frame_start) armed <= 1'b1;
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (snapshot) begin
          shadow[i] <= live_next[i];
          live[i]   <= '0;
        end else begin
          live[i]   <= live_next[i];
        end
      end
    end
  end

  // Zone under scan and whether it qualifies against the latched threshold.
  always_comb begin
    cur_cnt  = shadow[scan_idx];
    cur_qual = (cur_cnt >= thresh_q) && (cur_cnt != '0);
  end

  // Speed of the winner relative to its count at the previous RESULT, clamped to 10 bits.
  always_comb begin
    diff  = 32'(shadow[best_idx]) - 32'(prev[best_idx]);
    speed = 10'd0;
    if (shadow[best_idx] > prev[best_idx]) begin
      speed = (diff > 32'd1023) ? 10'd1023 : diff[9:0];
    end
  end

  // Control FSM: snapshot -> scan one zone per cycle -> decide and report.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state              <= ACCUM;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      collision_detected <= 1'b0;
      hit_zone           <= '0;
      hit_count          <= '0;
      estimated_speed    <= '0;
      thresh_q           <= '0;
      scan_idx           <= '0;
      best_idx           <= '0;
      best_cnt           <= '0;
      found              <= 1'b0;
      cooldown           <= '0;
      for (int i = 0; i < NUM_ZONES; i++) prev[i] <= '0;
    end else begin
      collision_detected <= 1'b0;
      frame_done         <= snapshot;
      case (state)
        ACCUM: begin
          if (snapshot) begin
            state    <= EVAL;
            busy     <= 1'b1;
            thresh_q <= thresh;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            found    <= 1'b0;
          end
        end
        EVAL: begin
          // Strictly greater keeps the lowest index on ties.
          if (cur_qual && (!found || (cur_cnt > best_cnt))) begin
            found    <= 1'b1;
            best_idx <= scan_idx;
            best_cnt <= cur_cnt;
          end
          if (scan_idx == ZW'(NUM_ZONES - 1)) begin
            state <= RESULT;
            busy  <= 1'b0;
          end else begin
            scan_idx <= scan_idx + ZW'(1);
          end
        end
        RESULT: begin
          if (found && enable && (cooldown == '0)) begin
            collision_detected <= 1'b1;
            hit_zone           <= best_idx;
            hit_count          <= best_cnt;
            estimated_speed    <= speed;
            cooldown           <= CD_W'(COOLDOWN_FRAMES);
          end else if (cooldown != '0) begin
            cooldown <= cooldown - CD_W'(1);
          end
          for (int i = 0; i < NUM_ZONES; i++) prev[i] <= shadow[i];
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
      // Disabling detection always releases any pending cooldown.
      if (!enable) cooldown <= '0;
    end
  end

endmodule

// File: tb/tb_hit_zone_detector.sv
// Bench for hit_zone_detector: two instances (cooldown 2 and cooldown 0) share
// one pixel stream; a frame-level reference model predicts every frame result.
module tb_hit_zone_detector;

  localparam int NZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic de = 1'b0;
  logic tgt = 1'b0;
  logic [9:0] xp = '0;
  logic [9:0] yp = '0;
  logic [NZ-1:0] area = '0;
  logic [11:0] thresh = '0;

  logic       coll [2];
  logic [1:0] hz   [2];
  logic [11:0] hc  [2];
  logic [9:0] spd  [2];
  logic       fd   [2];
  logic       bsy  [2];

  // clock / reset
  always #20 clk = ~clk;

  hit_zone_detector #(.COOLDOWN_FRAMES(2)) dut_a (
    .clk_25MHz(clk), .reset(rst_n), .enable(enable), .DE(de), .x_pixel(xp), .y_pixel(yp),
    .is_hit_area(area), .is_target_color(tgt), .thresh(thresh),
    .collision_detected(coll[0]), .hit_zone(hz[0]), .hit_count(hc[0]),
    .estimated_speed(spd[0]), .frame_done(fd[0]), .busy(bsy[0]));

  hit_zone_detector #(.COOLDOWN_FRAMES(0)) dut_b (
    .clk_25MHz(clk), .reset(rst_n), .enable(enable), .DE(de), .x_pixel(xp), .y_pixel(yp),
    .is_hit_area(area), .is_target_color(tgt), .thresh(thresh),
    .collision_detected(coll[1]), .hit_zone(hz[1]), .hit_count(hc[1]),
    .estimated_speed(spd[1]), .frame_done(fd[1]), .busy(bsy[1]));

  // reference model state
  int cool_p [2] = '{2, 0};
  bit m_armed;
  int m_live [NZ];
  int m_prev [2][NZ];
  int m_cool [2];
  int e_zone [2];
  int e_cnt  [2];
  int e_spd  [2];
  bit e_pulse [2];
  bit e_done;

  // per-frame expectation snapshot and observed 8-cycle windows after the last pixel
  bit x_done;
  bit x_pulse [2];
  logic [7:0] o_fd [2];
  logic [7:0] o_coll [2];
  logic [7:0] o_busy [2];

  int n_checks = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_armed = 1'b0;
    e_done = 1'b0;
    for (int i = 0; i < NZ; i++) m_live[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_cool[k] = 0; e_zone[k] = 0; e_cnt[k] = 0; e_spd[k] = 0; e_pulse[k] = 1'b0;
      for (int i = 0; i < NZ; i++) m_prev[k][i] = 0;
    end
  endtask

  // Frame verdict: first zone holding the largest qualifying count wins.
  task automatic model_frame_end();
    int win;
    int best;
    win = -1;
    best = 0;
    for (int i = 0; i < NZ; i++) begin
      if (m_live[i] >= int'(thresh) && m_live[i] > 0 && (win < 0 || m_live[i] > best)) begin
        win = i;
        best = m_live[i];
      end
    end
    e_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (win >= 0 && enable && m_cool[k] == 0) begin
        e_pulse[k] = 1'b1;
        e_zone[k] = win;
        e_cnt[k] = best;
        if (best > m_prev[k][win])
          e_spd[k] = (best - m_prev[k][win] > 1023) ? 1023 : best - m_prev[k][win];
        else
          e_spd[k] = 0;
        m_cool[k] = cool_p[k];
      end else if (m_cool[k] > 0) begin
        m_cool[k]--;
      end
      if (!enable) m_cool[k] = 0;
      for (int i = 0; i < NZ; i++) m_prev[k][i] = m_live[i];
    end
    for (int i = 0; i < NZ; i++) m_live[i] = 0;
  endtask

  // driver: present one pixel, update the model, advance one clock
  task automatic pixel(input logic d, input logic [9:0] x, input logic [9:0] y,
                       input logic [NZ-1:0] m, input logic t);
    bit is_start;
    bit is_end;
    de = d; xp = x; yp = y; area = m; tgt = t;
    is_start = d && x == 10'd0 && y == 10'd0;
    is_end = d && m_armed && x == 10'd639 && y == 10'd479;
    e_done = 1'b0;
    for (int k = 0; k < 2; k++) e_pulse[k] = 1'b0;
    if (is_start) begin
      m_armed = 1'b1;
      for (int i = 0; i < NZ; i++) m_live[i] = 0;
    end
    if (d && t && m_armed)
      for (int i = 0; i < NZ; i++) if (m[i] && m_live[i] < 4095) m_live[i]++;
    if (is_end) model_frame_end();
    @(posedge clk);
    #1;
  endtask

  // driver: optional start pixel, up to three hit segments, end pixel, then an 8-cycle idle window
  task automatic run_frame(input bit start_px, input bit rnd,
                           input int na, input logic [NZ-1:0] ma,
                           input int nb, input logic [NZ-1:0] mb,
                           input int nc, input logic [NZ-1:0] mc);
    int ns [3];
    logic [NZ-1:0] ms [3];
    ns = '{na, nb, nc};
    ms = '{ma, mb, mc};
    if (start_px) pixel(1'b1, 10'd0, 10'd0, rnd ? NZ'($urandom) : 4'b0000, rnd ? 1'($urandom) : 1'b0);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < ns[s]; i++) begin
        if (rnd && $urandom_range(0, 4) == 0)
          pixel(1'b0, 10'd0, 10'd0, 4'b1111, 1'b1);
        else
          pixel(1'b1, 10'($urandom_range(1, 600)), 10'($urandom_range(1, 400)),
                rnd ? NZ'($urandom) : ms[s], rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
    end
    pixel(1'b1, 10'd639, 10'd479, rnd ? NZ'($urandom) : 4'b1111, rnd ? 1'($urandom) : 1'b0);
    x_done = e_done;
    x_pulse = e_pulse;
    for (int j = 0; j < 2; j++) begin
      o_fd[j] = '0; o_coll[j] = '0; o_busy[j] = '0;
    end
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) pixel(1'b0, 10'd5, 10'd5, 4'b0000, 1'b0);
      for (int j = 0; j < 2; j++) begin
        o_fd[j][k-1] = fd[j];
        o_coll[j][k-1] = coll[j];
        o_busy[j][k-1] = bsy[j];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({coll[j], hz[j], hc[j], spd[j], fd[j], bsy[j]} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got coll=%b zone=%0d count=%0d speed=%0d done=%b busy=%b, expected all 0",
                 j, coll[j], hz[j], hc[j], spd[j], fd[j], bsy[j]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    enable = 1'b1;
    thresh = 12'd32;
    // partial frame after reset: never armed, so no snapshot
    run_frame(1'b0, 1'b0, 100, 4'b0001, 0, 4'b0000, 0, 4'b0000);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (o_fd[j] !== 8'h00 || o_coll[j] !== 8'h00) begin
        n_fail++;
        $display("FAIL unarmed_frame[%0d]: got done=%b coll=%b, expected 00000000 both", j, o_fd[j], o_coll[j]);
      end
    end
    run_frame(1'b1, 1'b0, 40, 4'b0001, 0, 4'b0000, 0, 4'b0000);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (o_fd[j] !== (x_done ? 8'h01 : 8'h00)) begin
        n_fail++;
        $display("FAIL first_done[%0d]: got %b expected %b", j, o_fd[j], x_done ? 8'h01 : 8'h00);
      end
      n_checks++;
      if (o_coll[j] !== (x_pulse[j] ? 8'h20 : 8'h00)) begin
        n_fail++;
        $display("FAIL first_coll[%0d]: got %b expected %b", j, o_coll[j], x_pulse[j] ? 8'h20 : 8'h00);
      end
      n_checks++;
      if (o_busy[j] !== (x_done ? 8'h0F : 8'h00)) begin
        n_fail++;
        $display("FAIL first_busy[%0d]: got %b expected %b", j, o_busy[j], x_done ? 8'h0F : 8'h00);
      end
      n_checks++;
      if (hz[j] !== 2'd0 || hc[j] !== 12'd40 || spd[j] !== 10'd40) begin
        n_fail++;
        $display("FAIL first_result[%0d]: got zone=%0d count=%0d speed=%0d expected 0/40/40", j, hz[j], hc[j], spd[j]);
      end
    end
  endtask

  task automatic test_tie_and_cooldown();
    enable = 1'b0;
    run_frame(1'b1, 1'b0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    enable = 1'b1;
    thresh = 12'd32;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) run_frame(1'b1, 1'b0, 50, 4'b0010, 50, 4'b0100, 20, 4'b1000);
      else        run_frame(1'b1, 1'b0, 60, 4'b0100, 0, 4'b0000, 0, 4'b0000);
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (o_fd[j] !== (x_done ? 8'h01 : 8'h00) || o_coll[j] !== (x_pulse[j] ? 8'h20 : 8'h00)) begin
          n_fail++;
          $display("FAIL tie_pulses[%0d] f%0d: got done=%b coll=%b expected done=%b coll=%b", j, f,
                   o_fd[j], o_coll[j], x_done ? 8'h01 : 8'h00, x_pulse[j] ? 8'h20 : 8'h00);
        end
        n_checks++;
        if (hz[j] !== 2'(e_zone[j]) || hc[j] !== 12'(e_cnt[j]) || spd[j] !== 10'(e_spd[j])) begin
          n_fail++;
          $display("FAIL tie_result[%0d] f%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", j, f,
                   hz[j], hc[j], spd[j], e_zone[j], e_cnt[j], e_spd[j]);
        end
      end
    end
    // cooldown instance still shows the tie winner and missed the second frame
    n_checks++;
    if (hz[0] !== 2'd1 || hc[0] !== 12'd50 || o_coll[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL tie_winner_held: got zone=%0d count=%0d coll=%b expected 1/50/00000000", hz[0], hc[0], o_coll[0]);
    end
    n_checks++;
    if (hz[1] !== 2'd2 || hc[1] !== 12'd60) begin
      n_fail++;
      $display("FAIL no_cooldown_winner: got zone=%0d count=%0d expected 2/60", hz[1], hc[1]);
    end
  endtask

  task automatic test_cooldown();
    logic [4:0] pat;
    logic [2:0] pat2;
    thresh = 12'd32;
    enable = 1'b0;
    run_frame(1'b1, 1'b0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    enable = 1'b1;
    pat = '0;
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b1, 1'b0, 40, 4'b0001, 0, 4'b0000, 0, 4'b0000);
      pat[f] = |o_coll[0];
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (o_coll[j] !== (x_pulse[j] ? 8'h20 : 8'h00)) begin
          n_fail++;
          $display("FAIL cooldown_coll[%0d] f%0d: got %b expected %b", j, f, o_coll[j], x_pulse[j] ? 8'h20 : 8'h00);
        end
      end
    end
    n_checks++;
    if (pat !== 5'b01001) begin
      n_fail++;
      $display("FAIL cooldown_pattern: got %b expected 01001", pat);
    end
    enable = 1'b0;
    run_frame(1'b1, 1'b0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    pat2 = '0;
    for (int f = 0; f < 3; f++) begin
      enable = (f != 1);
      run_frame(1'b1, 1'b0, 40, 4'b0001, 0, 4'b0000, 0, 4'b0000);
      pat2[f] = |o_coll[0];
      n_checks++;
      if (o_fd[0] !== 8'h01) begin
        n_fail++;
        $display("FAIL disabled_done f%0d: got %b expected 00000001", f, o_fd[0]);
      end
    end
    enable = 1'b1;
    n_checks++;
    if (pat2 !== 3'b101) begin
      n_fail++;
      $display("FAIL enable_clears_cooldown: got %b expected 101", pat2);
    end
  endtask

  task automatic test_speed();
    int counts [3];
    logic [9:0] got [3];
    counts = '{30, 70, 65};
    enable = 1'b1;
    thresh = 12'd10;
    run_frame(1'b1, 1'b0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b1, 1'b0, counts[f], 4'b0001, 0, 4'b0000, 0, 4'b0000);
      got[f] = spd[1];
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (o_coll[j] !== (x_pulse[j] ? 8'h20 : 8'h00) || spd[j] !== 10'(e_spd[j]) || hc[j] !== 12'(e_cnt[j])) begin
          n_fail++;
          $display("FAIL speed_frame[%0d] f%0d: got coll=%b count=%0d speed=%0d expected coll=%b count=%0d speed=%0d",
                   j, f, o_coll[j], hc[j], spd[j], x_pulse[j] ? 8'h20 : 8'h00, e_cnt[j], e_spd[j]);
        end
      end
    end
    n_checks++;
    if (got[0] !== 10'd30 || got[1] !== 10'd40 || got[2] !== 10'd0) begin
      n_fail++;
      $display("FAIL speed_sequence: got %0d,%0d,%0d expected 30,40,0", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_saturation_overlap();
    enable = 1'b1;
    thresh = 12'd10;
    run_frame(1'b1, 1'b0, 5000, 4'b0001, 0, 4'b0000, 0, 4'b0000);
    n_checks++;
    if (hz[1] !== 2'd0 || hc[1] !== 12'd4095 || spd[1] !== 10'd1023) begin
      n_fail++;
      $display("FAIL saturation: got zone=%0d count=%0d speed=%0d expected 0/4095/1023", hz[1], hc[1], spd[1]);
    end
    run_frame(1'b1, 1'b0, 30, 4'b0011, 0, 4'b0000, 0, 4'b0000);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (hz[j] !== 2'(e_zone[j]) || hc[j] !== 12'(e_cnt[j]) || spd[j] !== 10'(e_spd[j])) begin
        n_fail++;
        $display("FAIL overlap_result[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", j,
                 hz[j], hc[j], spd[j], e_zone[j], e_cnt[j], e_spd[j]);
      end
    end
    n_checks++;
    if (hz[1] !== 2'd0 || hc[1] !== 12'd30) begin
      n_fail++;
      $display("FAIL overlap_tie: got zone=%0d count=%0d expected 0/30", hz[1], hc[1]);
    end
  endtask

  task automatic test_reset_in_eval();
    enable = 1'b1;
    thresh = 12'd10;
    pixel(1'b1, 10'd0, 10'd0, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) pixel(1'b1, 10'd3, 10'd3, 4'b1000, 1'b1);
    pixel(1'b1, 10'd639, 10'd479, 4'b0000, 1'b0);
    pixel(1'b0, 10'd5, 10'd5, 4'b0000, 1'b0);
    pixel(1'b0, 10'd5, 10'd5, 4'b0000, 1'b0);
    n_checks++;
    if (bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL eval_busy: got %b expected 1", bsy[0]);
    end
    #5;
    rst_n = 1'b0;
    #2;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({coll[j], hz[j], hc[j], spd[j], fd[j], bsy[j]} !== 27'd0) begin
        n_fail++;
        $display("FAIL eval_reset[%0d]: got coll=%b zone=%0d count=%0d speed=%0d done=%b busy=%b, expected all 0",
                 j, coll[j], hz[j], hc[j], spd[j], fd[j], bsy[j]);
      end
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b1, 1'b0, 25, 4'b0100, 0, 4'b0000, 0, 4'b0000);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (o_coll[j] !== 8'h20 || hz[j] !== 2'd2 || hc[j] !== 12'd25 || spd[j] !== 10'd25) begin
        n_fail++;
        $display("FAIL after_eval_reset[%0d]: got coll=%b %0d/%0d/%0d expected 00100000 2/25/25",
                 j, o_coll[j], hz[j], hc[j], spd[j]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      enable = ($urandom_range(0, 5) != 0);
      thresh = 12'($urandom_range(0, 40));
      run_frame($urandom_range(0, 9) != 0, 1'b1, $urandom_range(0, 60), 4'b0000, 0, 4'b0000, 0, 4'b0000);
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (o_fd[j] !== (x_done ? 8'h01 : 8'h00) || o_busy[j] !== (x_done ? 8'h0F : 8'h00)) begin
          n_fail++;
          $display("FAIL rand_done[%0d] f%0d: got done=%b busy=%b expected done=%b busy=%b", j, f,
                   o_fd[j], o_busy[j], x_done ? 8'h01 : 8'h00, x_done ? 8'h0F : 8'h00);
        end
        n_checks++;
        if (o_coll[j] !== (x_pulse[j] ? 8'h20 : 8'h00)) begin
          n_fail++;
          $display("FAIL rand_coll[%0d] f%0d: got %b expected %b", j, f, o_coll[j], x_pulse[j] ? 8'h20 : 8'h00);
        end
        n_checks++;
        if (hz[j] !== 2'(e_zone[j]) || hc[j] !== 12'(e_cnt[j]) || spd[j] !== 10'(e_spd[j])) begin
          n_fail++;
          $display("FAIL rand_result[%0d] f%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", j, f,
                   hz[j], hc[j], spd[j], e_zone[j], e_cnt[j], e_spd[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_tie_and_cooldown();
    test_cooldown();
    test_speed();
    test_saturation_overlap();
    test_reset_in_eval();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
